// File: rtl/date_set_ctrl.sv
// -----------------------------------------------------------------------------
// date_set_ctrl
//
// Calendar date controller sitting beside external day/month/year counters.
// In RUN it advances the date on every midnight tick (month lengths and leap
// years included). In the three SET states the operator steps one field at a
// time with btn_inc. On leaving SET_YEAR, a day that no longer fits the chosen
// month/year is clamped to the last valid day.
//
// The counters are never written directly. Each change is issued as a
// registered one-cycle load strobe with its load value. The counters take the
// load on the same edge that drops the strobe. As a result, the counter inputs
// are one cycle stale while any strobe is high, and tick/increment events that
// arrive in that cycle are dropped.
//
// Ports
//   clk         in   system clock, rising edge
//   clear       in   synchronous active-high reset
//   day_tick    in   one-cycle pulse at midnight rollover
//   btn_mode    in   debounced pulse, advances RUN->SET_DAY->SET_MONTH->SET_YEAR->RUN
//   btn_inc     in   debounced pulse, increments the field being set
//   day         in   current day counter   (1..31)
//   month       in   current month counter (1..12)
//   year        in   current year counter  (0..60, 0 = 2000)
//   day_ld      out  day load strobe (one cycle)
//   month_ld    out  month load strobe (one cycle)
//   year_ld     out  year load strobe (one cycle)
//   day_data    out  day load value, 0 while day_ld is low
//   month_data  out  month load value, 0 while month_ld is low
//   year_data   out  year load value, 0 while year_ld is low
//   disp_sel    out  databus field: 00 run, 01 day, 10 month, 11 year
//   set_mode    out  high in any SET state
// -----------------------------------------------------------------------------
module date_set_ctrl #(
  parameter int DATA_W   = 8,
  parameter int YEAR_MAX = 60
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              day_tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [DATA_W-1:0] day,
  input  logic [DATA_W-1:0] month,
  input  logic [DATA_W-1:0] year,
  output logic              day_ld,
  output logic              month_ld,
  output logic              year_ld,
  output logic [DATA_W-1:0] day_data,
  output logic [DATA_W-1:0] month_data,
  output logic [DATA_W-1:0] year_data,
  output logic [1:0]        disp_sel,
  output logic              set_mode
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_DAY   = 2'b01,
    SET_MONTH = 2'b10,
    SET_YEAR  = 2'b11
  } state_t;

  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] DEC       = DATA_W'(12);
  localparam logic [DATA_W-1:0] YEAR_LAST = DATA_W'(YEAR_MAX);

  // Length of month m in year y. Every year divisible by 4 in 2000..2060 is a
  // leap year, so the two low bits of the offset are enough.
  function automatic logic [DATA_W-1:0] days_in_month(
    input logic [DATA_W-1:0] m,
    input logic [DATA_W-1:0] y
  );
    logic [DATA_W-1:0] d;
    case (m)
      DATA_W'(4), DATA_W'(6), DATA_W'(9), DATA_W'(11): d = DATA_W'(30);
      DATA_W'(2): d = (y[1:0] == 2'b00) ? DATA_W'(29) : DATA_W'(28);
      default:    d = DATA_W'(31);
    endcase
    return d;
  endfunction

  // Increment with wrap. The >= checks also pull an out-of-range counter
  // value back into range.
  function automatic logic [DATA_W-1:0] wrap_day(
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] dim
  );
    return (d >= dim) ? ONE : d + ONE;
  endfunction

  function automatic logic [DATA_W-1:0] wrap_month(input logic [DATA_W-1:0] m);
    return (m >= DEC) ? ONE : m + ONE;
  endfunction

  function automatic logic [DATA_W-1:0] wrap_year(input logic [DATA_W-1:0] y);
    return (y >= YEAR_LAST) ? '0 : y + ONE;
  endfunction

  // Clamp a day into the month; leaves valid days untouched.
  function automatic logic [DATA_W-1:0] clamp_day(
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] dim
  );
    return (d > dim) ? dim : d;
  endfunction

  state_t state_q, state_nxt;

  logic              day_ld_p0, month_ld_p0, year_ld_p0;
  logic [DATA_W-1:0] day_data_p0, month_data_p0, year_data_p0;
  logic              day_ld_p1, month_ld_p1, year_ld_p1;
  logic [DATA_W-1:0] day_data_p1, month_data_p1, year_data_p1;

  logic              stale_p0;
  logic              tick_ok_p0;
  logic              inc_ok_p0;
  logic [DATA_W-1:0] dim_p0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. btn_mode is the only way to move. It is not gated by
  // pending strobes because it does not depend on the counter values.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    if (btn_mode) begin
      case (state_q)
        RUN:       state_nxt = SET_DAY;
        SET_DAY:   state_nxt = SET_MONTH;
        SET_MONTH: state_nxt = SET_YEAR;
        SET_YEAR:  state_nxt = RUN;
        default:   state_nxt = RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_sel = 2'b00;
    set_mode = 1'b0;
    case (state_q)
      RUN:       begin disp_sel = 2'b00; set_mode = 1'b0; end
      SET_DAY:   begin disp_sel = 2'b01; set_mode = 1'b1; end
      SET_MONTH: begin disp_sel = 2'b10; set_mode = 1'b1; end
      SET_YEAR:  begin disp_sel = 2'b11; set_mode = 1'b1; end
      default:   begin disp_sel = 2'b00; set_mode = 1'b0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p0: decode events against the current counter values
  // ---------------------------------------------------------------------------
  always_comb begin
    day_ld_p0     = 1'b0;
    month_ld_p0   = 1'b0;
    year_ld_p0    = 1'b0;
    day_data_p0   = '0;
    month_data_p0 = '0;
    year_data_p0  = '0;

    // A strobe in flight means the counters have not yet taken the load.
    stale_p0   = day_ld_p1 | month_ld_p1 | year_ld_p1;
    tick_ok_p0 = day_tick & ~stale_p0;
    inc_ok_p0  = btn_inc & ~btn_mode & ~stale_p0;
    dim_p0     = days_in_month(month, year);

    case (state_q)
      RUN: begin
        if (tick_ok_p0) begin
          day_ld_p0 = 1'b1;
          if (day < dim_p0) begin
            day_data_p0 = day + ONE;
          end else begin
            day_data_p0 = ONE;
            month_ld_p0 = 1'b1;
            if (month < DEC) begin
              month_data_p0 = month + ONE;
            end else begin
              month_data_p0 = ONE;
              year_ld_p0    = 1'b1;
              year_data_p0  = wrap_year(year);
            end
          end
        end
      end

      SET_DAY: begin
        if (inc_ok_p0) begin
          day_ld_p0   = 1'b1;
          day_data_p0 = wrap_day(day, dim_p0);
        end
      end

      SET_MONTH: begin
        if (inc_ok_p0) begin
          month_ld_p0   = 1'b1;
          month_data_p0 = wrap_month(month);
        end
      end

      SET_YEAR: begin
        if (inc_ok_p0) begin
          year_ld_p0   = 1'b1;
          year_data_p0 = wrap_year(year);
        end
        // Leaving set mode: the month or year may have shortened the month
        // under the current day.
        if (btn_mode && (day > dim_p0)) begin
          day_ld_p0   = 1'b1;
          day_data_p0 = clamp_day(day, dim_p0);
        end
      end

      default: begin
        day_ld_p0 = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered strobes and load values. clear zeroes the data as
  // well, so no stale load value survives a reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear) begin
      day_ld_p1     <= 1'b0;
      month_ld_p1   <= 1'b0;
      year_ld_p1    <= 1'b0;
      day_data_p1   <= '0;
      month_data_p1 <= '0;
      year_data_p1  <= '0;
    end else begin
      day_ld_p1     <= day_ld_p0;
      month_ld_p1   <= month_ld_p0;
      year_ld_p1    <= year_ld_p0;
      day_data_p1   <= day_data_p0;
      month_data_p1 <= month_data_p0;
      year_data_p1  <= year_data_p0;
    end
  end

  assign day_ld     = day_ld_p1;
  assign month_ld   = month_ld_p1;
  assign year_ld    = year_ld_p1;
  assign day_data   = day_data_p1;
  assign month_data = month_data_p1;
  assign year_data  = year_data_p1;

endmodule

// File: tb/tb_date_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_date_set_ctrl
//
// Directed scenarios for the date controller (tick rollovers, field setting,
// exit clamp, reset), followed by a long randomized run checked against a
// behavioural model of the calendar rules.
// Observed outputs are packed as:
//   {day_ld, month_ld, year_ld, day_data, month_data, year_data, disp_sel, set_mode}
// -----------------------------------------------------------------------------
module tb_date_set_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       day_tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] day = 8'd1;
  logic [7:0] month = 8'd1;
  logic [7:0] year = 8'd0;
  logic       day_ld, month_ld, year_ld;
  logic [7:0] day_data, month_data, year_data;
  logic [1:0] disp_sel;
  logic       set_mode;

  int vectors = 0;
  int miscompares = 0;

  date_set_ctrl dut (
    .clk        (clk),
    .clear      (clear),
    .day_tick   (day_tick),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .day        (day),
    .month      (month),
    .year       (year),
    .day_ld     (day_ld),
    .month_ld   (month_ld),
    .year_ld    (year_ld),
    .day_data   (day_data),
    .month_data (month_data),
    .year_data  (year_data),
    .disp_sel   (disp_sel),
    .set_mode   (set_mode)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {day_ld, month_ld, year_ld, day_data, month_data, year_data, disp_sel, set_mode};

  // Expected-output packer.
  function automatic logic [29:0] ev(input logic dl, ml, yl, input int dd, md, yd, ds, sm);
    return {dl, ml, yl, 8'(dd), 8'(md), 8'(yd), 2'(ds), 1'(sm)};
  endfunction

  // One directed step: {clear, tick, mode, inc, day, month, year, expected}.
  function automatic logic [57:0] st(input logic c, t, bm, bi, input int d, m, y,
                                     input logic [29:0] e);
    return {c, t, bm, bi, 8'(d), 8'(m), 8'(y), e};
  endfunction

  // Apply inputs for one clock, then sample 1 ns after the rising edge.
  task automatic drive(input logic c, t, bm, bi, input logic [7:0] d, m, y);
    clear = c; day_tick = t; btn_mode = bm; btn_inc = bi;
    day = d; month = m; year = y;
    @(posedge clk);
    #1;
    clear = 1'b0; day_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  // Runs a step list; each step's outputs are compared after its edge.
  task automatic run_steps(input string tname, input logic [57:0] q[$]);
    for (int i = 0; i < q.size(); i++) begin
      logic [57:0] s;
      s = q[i];
      drive(s[57], s[56], s[55], s[54], s[53:46], s[45:38], s[37:30]);
      vectors++;
      if (obs !== s[29:0]) begin
        miscompares++;
        $display("FAIL %s step %0d: got %h want %h", tname, i, obs, s[29:0]);
      end
    end
  endtask

  localparam logic [29:0] Z = 30'h0;

  task automatic test_reset();
    logic [57:0] q[$];
    q.push_back(st(1, 1, 1, 1, 15, 3, 5, Z));
    q.push_back(st(1, 0, 0, 0, 15, 3, 5, Z));
    q.push_back(st(0, 0, 0, 0, 15, 3, 5, Z));
    run_steps("reset", q);
  endtask

  task automatic test_run_tick();
    logic [57:0] q[$];
    q.push_back(st(0, 0, 0, 1, 15, 3, 5, Z));                         // inc ignored in RUN
    q.push_back(st(0, 1, 0, 0, 15, 3, 5, ev(1, 0, 0, 16, 0, 0, 0, 0)));
    q.push_back(st(0, 1, 0, 0, 15, 3, 5, Z));                         // tick during strobe dropped
    q.push_back(st(0, 1, 0, 0, 16, 3, 5, ev(1, 0, 0, 17, 0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 17, 3, 5, Z));
    q.push_back(st(0, 1, 0, 0, 28, 2, 4, ev(1, 0, 0, 29, 0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 29, 2, 4, Z));
    q.push_back(st(0, 1, 0, 0, 28, 2, 5, ev(1, 1, 0, 1, 3, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 1, 3, 5, Z));
    q.push_back(st(0, 1, 0, 0, 30, 4, 5, ev(1, 1, 0, 1, 5, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 1, 5, 5, Z));
    q.push_back(st(0, 1, 0, 0, 29, 2, 0, ev(1, 1, 0, 1, 3, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 1, 3, 0, Z));
    q.push_back(st(0, 1, 0, 0, 31, 12, 60, ev(1, 1, 1, 1, 1, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 1, 1, 0, Z));
    q.push_back(st(0, 1, 0, 0, 31, 12, 7, ev(1, 1, 1, 1, 1, 8, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 1, 1, 8, Z));
    run_steps("run_tick", q);
  endtask

  task automatic test_set_fields();
    logic [57:0] q[$];
    q.push_back(st(0, 0, 1, 0, 30, 4, 5, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 0, 1, 30, 4, 5, ev(1, 0, 0, 1, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 0, 1, 1, 4, 5, ev(0, 0, 0, 0, 0, 0, 1, 1))); // stale inc dropped
    q.push_back(st(0, 0, 0, 1, 1, 4, 5, ev(1, 0, 0, 2, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 0, 0, 2, 4, 5, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 1, 0, 0, 2, 4, 5, ev(0, 0, 0, 0, 0, 0, 1, 1))); // tick ignored
    q.push_back(st(0, 0, 0, 1, 29, 2, 5, ev(1, 0, 0, 1, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 0, 0, 1, 2, 5, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 1, 1, 10, 4, 5, ev(0, 0, 0, 0, 0, 0, 2, 1))); // mode wins
    q.push_back(st(0, 1, 0, 0, 15, 3, 5, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 1, 15, 12, 5, ev(0, 1, 0, 0, 1, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 0, 15, 1, 5, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 1, 15, 7, 5, ev(0, 1, 0, 0, 8, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 0, 15, 8, 5, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 0, 1, 0, 15, 7, 5, ev(0, 0, 0, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 0, 1, 15, 7, 60, ev(0, 0, 1, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 0, 0, 15, 7, 0, ev(0, 0, 0, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 0, 1, 15, 7, 59, ev(0, 0, 1, 0, 0, 60, 3, 1)));
    q.push_back(st(0, 0, 0, 0, 15, 7, 60, ev(0, 0, 0, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 1, 0, 15, 7, 60, Z));                        // exit, no clamp
    q.push_back(st(0, 0, 0, 1, 15, 7, 60, Z));
    run_steps("set_fields", q);
  endtask

  task automatic test_exit_clamp();
    logic [57:0] q[$];
    q.push_back(st(0, 0, 1, 0, 31, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 1, 0, 31, 1, 0, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 1, 31, 1, 0, ev(0, 1, 0, 0, 2, 0, 2, 1)));
    q.push_back(st(0, 0, 0, 0, 31, 2, 0, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 0, 1, 0, 31, 2, 0, ev(0, 0, 0, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 0, 1, 31, 2, 0, ev(0, 0, 1, 0, 0, 1, 3, 1)));
    q.push_back(st(0, 0, 0, 0, 31, 2, 1, ev(0, 0, 0, 0, 0, 0, 3, 1)));
    q.push_back(st(0, 0, 1, 0, 31, 2, 1, ev(1, 0, 0, 28, 0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 28, 2, 1, Z));
    for (int k = 0; k < 3; k++)
      q.push_back(st(0, 0, 1, 0, 31, 2, 4, ev(0, 0, 0, 0, 0, 0, k + 1, 1)));
    q.push_back(st(0, 0, 1, 0, 31, 2, 4, ev(1, 0, 0, 29, 0, 0, 0, 0)));
    q.push_back(st(0, 0, 0, 0, 29, 2, 4, Z));
    for (int k = 0; k < 3; k++)
      q.push_back(st(0, 0, 1, 0, 31, 9, 4, ev(0, 0, 0, 0, 0, 0, k + 1, 1)));
    q.push_back(st(0, 0, 1, 1, 31, 9, 4, ev(1, 0, 0, 30, 0, 0, 0, 0))); // inc dropped
    q.push_back(st(0, 0, 0, 0, 30, 9, 4, Z));
    run_steps("exit_clamp", q);
  endtask

  task automatic test_clear_mid();
    logic [57:0] q[$];
    q.push_back(st(0, 0, 1, 0, 15, 3, 5, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 1, 0, 15, 3, 5, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(0, 1, 0, 0, 15, 3, 5, ev(0, 0, 0, 0, 0, 0, 2, 1)));
    q.push_back(st(1, 0, 0, 1, 15, 3, 5, Z));
    q.push_back(st(0, 0, 0, 0, 15, 3, 5, Z));
    q.push_back(st(0, 1, 0, 0, 15, 3, 5, ev(1, 0, 0, 16, 0, 0, 0, 0))); // back in RUN
    q.push_back(st(1, 0, 0, 0, 16, 3, 5, Z));                          // clear kills strobe
    q.push_back(st(1, 1, 0, 0, 20, 3, 5, Z));
    q.push_back(st(0, 0, 1, 0, 20, 3, 5, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    q.push_back(st(0, 0, 0, 1, 20, 3, 5, ev(1, 0, 0, 21, 0, 0, 1, 1)));
    q.push_back(st(1, 0, 0, 1, 21, 3, 5, Z));
    q.push_back(st(0, 0, 0, 0, 21, 3, 5, Z));
    run_steps("clear_mid", q);
  endtask

  // ---- Behavioural model for the randomized run ----
  int mdl_mode = 0;       // 0 run, 1 day, 2 month, 3 year
  bit mdl_pending = 0;    // a load issued last cycle is still being absorbed

  function automatic int dim_ref(input int m, input int y);
    int len[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0) return 29;
    return len[m - 1];
  endfunction

  task automatic model_step(input bit c, t, bm, bi, input int d, m, y,
                            output logic [29:0] e);
    bit dl = 0, ml = 0, yl = 0;
    int dd = 0, md = 0, yd = 0;
    int len;
    len = dim_ref(m, y);
    if (c) begin
      mdl_mode = 0;
    end else begin
      if (mdl_mode == 0 && t && !mdl_pending) begin
        dl = 1;
        if (d < len) dd = d + 1;
        else begin
          dd = 1; ml = 1;
          if (m < 12) md = m + 1;
          else begin md = 1; yl = 1; yd = (y == 60) ? 0 : y + 1; end
        end
      end
      if (bi && !bm && !mdl_pending) begin
        if (mdl_mode == 1) begin dl = 1; dd = (d >= len) ? 1 : d + 1; end
        if (mdl_mode == 2) begin ml = 1; md = (m >= 12) ? 1 : m + 1; end
        if (mdl_mode == 3) begin yl = 1; yd = (y >= 60) ? 0 : y + 1; end
      end
      if (bm && mdl_mode == 3 && d > len) begin dl = 1; dd = len; end
      if (bm) mdl_mode = (mdl_mode + 1) % 4;
    end
    mdl_pending = dl | ml | yl;
    e = ev(dl, ml, yl, dd, md, yd, mdl_mode, (mdl_mode != 0) ? 1 : 0);
  endtask

  task automatic test_random();
    logic [29:0] e;
    bit c, t, bm, bi;
    int d, m, y;
    drive(1, 0, 0, 0, 8'd1, 8'd1, 8'd0);
    mdl_mode = 0;
    mdl_pending = 0;
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 99) == 0);
      t  = ($urandom_range(0, 3) == 0);
      bm = ($urandom_range(0, 5) == 0);
      bi = ($urandom_range(0, 1) == 0);
      m  = $urandom_range(1, 12);
      y  = ($urandom_range(0, 7) == 0) ? 60 : $urandom_range(0, 60);
      // RUN ticks are only defined for a valid day; set states accept any day.
      d  = (mdl_mode == 0) ? $urandom_range(1, dim_ref(m, y)) : $urandom_range(1, 31);
      if ($urandom_range(0, 5) == 0 && mdl_mode == 0) d = dim_ref(m, y);
      if ($urandom_range(0, 9) == 0) m = 12;
      if (mdl_mode == 0 && d > dim_ref(m, y)) d = dim_ref(m, y);
      model_step(c, t, bm, bi, d, m, y, e);
      drive(c, t, bm, bi, 8'(d), 8'(m), 8'(y));
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_set_fields();
    test_exit_clamp();
    test_clear_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
